// File: rtl/psg_pkg.sv
// psg_pkg: shared bus encodings, register indices and write-mask table for the PSG register bus
package psg_pkg;

    typedef enum logic [1:0] {
        BUS_INACT = 2'b00,
        BUS_READ  = 2'b01,
        BUS_WRITE = 2'b10,
        BUS_LATCH = 2'b11
    } bus_e;

    localparam logic [3:0] R_TONE_A_L  = 4'd0;
    localparam logic [3:0] R_TONE_A_H  = 4'd1;
    localparam logic [3:0] R_TONE_B_L  = 4'd2;
    localparam logic [3:0] R_TONE_B_H  = 4'd3;
    localparam logic [3:0] R_TONE_C_L  = 4'd4;
    localparam logic [3:0] R_TONE_C_H  = 4'd5;
    localparam logic [3:0] R_NOISE     = 4'd6;
    localparam logic [3:0] R_MIXER     = 4'd7;
    localparam logic [3:0] R_VOL_A     = 4'd8;
    localparam logic [3:0] R_VOL_B     = 4'd9;
    localparam logic [3:0] R_VOL_C     = 4'd10;
    localparam logic [3:0] R_ENV_L     = 4'd11;
    localparam logic [3:0] R_ENV_H     = 4'd12;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;
    localparam logic [3:0] R_IOA       = 4'd14;
    localparam logic [3:0] R_IOB       = 4'd15;

    // Implemented bits per register; unimplemented bits are stored and read as 0.
    function automatic logic [7:0] reg_mask(input logic [3:0] a);
        return (a == R_TONE_A_H || a == R_TONE_B_H || a == R_TONE_C_H || a == R_ENV_SHAPE) ? 8'h0F :
               (a == R_NOISE || a == R_VOL_A || a == R_VOL_B || a == R_VOL_C)            ? 8'h1F :
                                                                                            8'hFF;
    endfunction

endpackage

// File: rtl/psg_bus_decode.sv
// psg_bus_decode: turns sampled BDIR/BC into per-cycle latch/write/read/idle strobes plus a write-entry strobe
//   I_clk, I_reset : clock, async active-high reset
//   I_ena          : bus-sample enable; all strobes are low when 0
//   I_bdir, I_bc   : bus control pins
//   O_latch/O_write/O_read/O_idle : decoded bus cycle on an enabled sample
//   O_write_entry  : first enabled write sample after any non-write sample
module psg_bus_decode
    import psg_pkg::*;
(
    input  logic I_clk,
    input  logic I_reset,
    input  logic I_ena,
    input  logic I_bdir,
    input  logic I_bc,
    output logic O_latch,
    output logic O_write,
    output logic O_read,
    output logic O_idle,
    output logic O_write_entry
);

    bus_e bus;
    bus_e prev_bus;

    assign bus           = bus_e'({I_bdir, I_bc});
    assign O_latch       = I_ena && bus == BUS_LATCH;
    assign O_write       = I_ena && bus == BUS_WRITE;
    assign O_read        = I_ena && bus == BUS_READ;
    assign O_idle        = I_ena && bus == BUS_INACT;
    assign O_write_entry = O_write && prev_bus != BUS_WRITE;

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset)
            prev_bus <= BUS_INACT;
        else if (I_ena)
            prev_bus <= bus;
    end

endmodule

// File: rtl/psg_bus_responder.sv
// psg_bus_responder: PSG bus responder with a 16-entry YM2149-style register file and decoded sound parameters
//   I_clk, I_reset        : clock, async active-high reset
//   I_ena, I_bdir, I_bc   : bus enable and control; I_di carries address or data
//   O_do                  : registered read data, DO_IDLE when not reading or deselected
//   I_ioa_in, I_iob_in    : I/O port pins, read back when the port is configured as input
//   O_tone_*, O_noise, O_mixer, O_vol_*, O_env_* : register fields for the generators
//   O_env_restart         : one-cycle pulse after a write entry into the envelope shape register
//   O_ioa_out, O_iob_out  : I/O port output latches; O_selected : chip-select state
module psg_bus_responder
    import psg_pkg::*;
#(
    parameter logic [3:0] ADDR_HI = 4'h0,
    parameter logic [7:0] DO_IDLE = 8'hFF
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_ena,
    input  logic        I_bdir,
    input  logic        I_bc,
    input  logic [7:0]  I_di,
    output logic [7:0]  O_do,
    input  logic [7:0]  I_ioa_in,
    input  logic [7:0]  I_iob_in,
    output logic [11:0] O_tone_a,
    output logic [11:0] O_tone_b,
    output logic [11:0] O_tone_c,
    output logic [4:0]  O_noise,
    output logic [7:0]  O_mixer,
    output logic [4:0]  O_vol_a,
    output logic [4:0]  O_vol_b,
    output logic [4:0]  O_vol_c,
    output logic [15:0] O_env_period,
    output logic [3:0]  O_env_shape,
    output logic        O_env_restart,
    output logic [7:0]  O_ioa_out,
    output logic [7:0]  O_iob_out,
    output logic        O_selected
);

    logic [7:0] regs [16];
    logic [3:0] addr;
    logic       selected;
    logic [7:0] do_q;
    logic       env_restart;
    logic       latch, write, read, idle, write_entry;
    logic [7:0] rd_val;

    psg_bus_decode u_decode (
        .I_clk         (I_clk),
        .I_reset       (I_reset),
        .I_ena         (I_ena),
        .I_bdir        (I_bdir),
        .I_bc          (I_bc),
        .O_latch       (latch),
        .O_write       (write),
        .O_read        (read),
        .O_idle        (idle),
        .O_write_entry (write_entry)
    );

    // Mixer bits 6/7 select port direction; an input port reads its pins.
    always_comb begin
        rd_val = (addr == R_IOA && !regs[R_MIXER][6]) ? I_ioa_in :
                 (addr == R_IOB && !regs[R_MIXER][7]) ? I_iob_in :
                                                        regs[addr];
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
            addr        <= '0;
            selected    <= 1'b0;
            do_q        <= DO_IDLE;
            env_restart <= 1'b0;
        end else begin
            env_restart <= write_entry && selected && addr == R_ENV_SHAPE;
            if (latch) begin
                selected <= I_di[7:4] == ADDR_HI;
                if (I_di[7:4] == ADDR_HI)
                    addr <= I_di[3:0];
            end
            if (write && selected)
                regs[addr] <= I_di & reg_mask(addr);
            if (read)
                do_q <= selected ? rd_val : DO_IDLE;
            if (idle)
                do_q <= DO_IDLE;
        end
    end

    assign O_do          = do_q;
    assign O_tone_a      = {regs[R_TONE_A_H][3:0], regs[R_TONE_A_L]};
    assign O_tone_b      = {regs[R_TONE_B_H][3:0], regs[R_TONE_B_L]};
    assign O_tone_c      = {regs[R_TONE_C_H][3:0], regs[R_TONE_C_L]};
    assign O_noise       = regs[R_NOISE][4:0];
    assign O_mixer       = regs[R_MIXER];
    assign O_vol_a       = regs[R_VOL_A][4:0];
    assign O_vol_b       = regs[R_VOL_B][4:0];
    assign O_vol_c       = regs[R_VOL_C][4:0];
    assign O_env_period  = {regs[R_ENV_H], regs[R_ENV_L]};
    assign O_env_shape   = regs[R_ENV_SHAPE][3:0];
    assign O_env_restart = env_restart;
    assign O_ioa_out     = regs[R_IOA];
    assign O_iob_out     = regs[R_IOB];
    assign O_selected    = selected;

endmodule

// File: tb/tb_psg_bus_responder.sv
// tb_psg_bus_responder: directed self-checking bench for psg_bus_responder
module tb_psg_bus_responder;

    logic        I_clk = 1'b0;
    logic        I_reset = 1'b1;
    logic        I_ena = 1'b1;
    logic        I_bdir = 1'b0;
    logic        I_bc = 1'b0;
    logic [7:0]  I_di = 8'h00;
    logic [7:0]  O_do;
    logic [7:0]  I_ioa_in = 8'h00;
    logic [7:0]  I_iob_in = 8'h00;
    logic [11:0] O_tone_a, O_tone_b, O_tone_c;
    logic [4:0]  O_noise, O_vol_a, O_vol_b, O_vol_c;
    logic [7:0]  O_mixer, O_ioa_out, O_iob_out;
    logic [15:0] O_env_period;
    logic [3:0]  O_env_shape;
    logic        O_env_restart, O_selected;

    int checks = 0;
    int errors = 0;

    psg_bus_responder dut (
        .I_clk         (I_clk),
        .I_reset       (I_reset),
        .I_ena         (I_ena),
        .I_bdir        (I_bdir),
        .I_bc          (I_bc),
        .I_di          (I_di),
        .O_do          (O_do),
        .I_ioa_in      (I_ioa_in),
        .I_iob_in      (I_iob_in),
        .O_tone_a      (O_tone_a),
        .O_tone_b      (O_tone_b),
        .O_tone_c      (O_tone_c),
        .O_noise       (O_noise),
        .O_mixer       (O_mixer),
        .O_vol_a       (O_vol_a),
        .O_vol_b       (O_vol_b),
        .O_vol_c       (O_vol_c),
        .O_env_period  (O_env_period),
        .O_env_shape   (O_env_shape),
        .O_env_restart (O_env_restart),
        .O_ioa_out     (O_ioa_out),
        .O_iob_out     (O_iob_out),
        .O_selected    (O_selected)
    );

    always #5 I_clk = ~I_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus sample: drive at negedge, outputs observed 1 time unit after the posedge.
    task automatic cyc(input logic b, input logic c, input logic [7:0] d);
        @(negedge I_clk);
        I_bdir = b;
        I_bc   = c;
        I_di   = d;
        @(posedge I_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b1, a);
        cyc(1'b1, 1'b0, d);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [7:0] a);
        cyc(1'b1, 1'b1, a);
        cyc(1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        repeat (2) @(posedge I_clk);
        @(negedge I_clk);
        I_reset = 1'b0;
        #1;
        chk("rst_tone_a", O_tone_a, 0);
        chk("rst_env_period", O_env_period, 0);
        chk("rst_vol_a", O_vol_a, 0);
        chk("rst_do", O_do, 8'hFF);
        chk("rst_sel", O_selected, 0);
        chk("rst_restart", O_env_restart, 0);

        wr(8'h00, 8'hAC);
        wr(8'h01, 8'hF1);
        chk("tone_a", O_tone_a, 12'h1AC);
        rd(8'h01);
        chk("rd_r1_masked", O_do, 8'h01);
        cyc(1'b0, 1'b0, 8'h00);
        chk("do_idle", O_do, 8'hFF);

        wr(8'h06, 8'hFF);
        chk("noise_mask", O_noise, 5'h1F);
        wr(8'h0B, 8'h34);
        wr(8'h0C, 8'h12);
        chk("env_period", O_env_period, 16'h1234);

        cyc(1'b1, 1'b1, 8'h0D);
        cyc(1'b1, 1'b0, 8'h0A);
        chk("restart_pulse", O_env_restart, 1);
        chk("env_shape", O_env_shape, 4'hA);
        cyc(1'b1, 1'b0, 8'h0A);
        chk("restart_hold1", O_env_restart, 0);
        cyc(1'b1, 1'b0, 8'h0A);
        chk("restart_hold2", O_env_restart, 0);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h0A);
        chk("restart_again", O_env_restart, 1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("restart_clear", O_env_restart, 0);

        cyc(1'b1, 1'b1, 8'h27);
        chk("foreign_sel", O_selected, 0);
        cyc(1'b1, 1'b0, 8'h55);
        chk("foreign_wr_shape", O_env_shape, 4'hA);
        chk("foreign_wr_tone", O_tone_a, 12'h1AC);
        cyc(1'b0, 1'b1, 8'h00);
        chk("foreign_rd", O_do, 8'hFF);

        wr(8'h07, 8'h00);
        I_ioa_in = 8'h3C;
        I_iob_in = 8'h5A;
        wr(8'h0E, 8'h99);
        rd(8'h0E);
        chk("ioa_input", O_do, 8'h3C);
        rd(8'h0F);
        chk("iob_input", O_do, 8'h5A);
        wr(8'h07, 8'h40);
        chk("mixer", O_mixer, 8'h40);
        rd(8'h0E);
        chk("ioa_output", O_do, 8'h99);
        chk("ioa_out", O_ioa_out, 8'h99);

        I_ena = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        chk("ena_hold_do", O_do, 8'h99);
        cyc(1'b1, 1'b0, 8'h11);
        chk("ena_hold_wr", O_ioa_out, 8'h99);
        I_ena = 1'b1;

        wr(8'h08, 8'h0F);
        chk("vol_a", O_vol_a, 5'h0F);
        cyc(1'b1, 1'b1, 8'h08);
        cyc(1'b1, 1'b0, 8'h0F);
        @(negedge I_clk);
        I_reset = 1'b1;
        #1;
        chk("rst_mid_vol", O_vol_a, 0);
        chk("rst_mid_sel", O_selected, 0);
        chk("rst_mid_do", O_do, 8'hFF);
        @(negedge I_clk);
        I_reset = 1'b0;
        cyc(1'b1, 1'b0, 8'h1F);
        cyc(1'b1, 1'b0, 8'h1F);
        chk("post_rst_wr_drop", O_vol_a, 0);
        cyc(1'b0, 1'b0, 8'h00);
        wr(8'h08, 8'hFF);
        chk("vol_mask", O_vol_a, 5'h1F);
        chk("post_rst_tone", O_tone_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
